truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that drives a 4-input combinational function block through all 16 input combinations in ascending order. It holds each vector for a programmable dwell time and samples the block's output f. It assembles the 16-bit measured truth table, compares it bit-by-bit against an expected table and reports pass/fail, mismatch count and first failing vector. It sits between the combinational function block and the lab top level or self-checking harness, and replaces hand-written exhaustive stimulus.

Parameters:
N_IN, 4, number of function inputs; table width is 2**N_IN.
DWELL, 2, cycles each vector is held before the sample cycle; legal range 1..15.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin sweep; accepted only in IDLE or DONE.
expected  input  2**N_IN  expected truth table; bit k = f for input vector k; latched when start is accepted.
f_in  input  1  output f of the function block under control.
abcd_out  output  N_IN  vector driven to the function block; MSB = A, LSB = D.
busy  output  1  high in APPLY and SAMPLE.
done  output  1  high in DONE; held until next accepted start or rst.
pass  output  1  valid while done; 1 iff measured table == latched expected.
table_out  output  2**N_IN  measured truth table; bit k = f_in sampled for vector k.
mismatch_cnt  output  N_IN+1  number of differing bits (0..16).
first_fail  output  N_IN  lowest vector index that mismatched.
first_fail_valid  output  1  1 once any mismatch has been recorded.

Behaviour:
- Reset (rst=1 at rising edge, any state including mid-sweep): state=IDLE, abcd_out=0, busy=0, done=0, pass=0, table_out=0, mismatch_cnt=0, first_fail=0, first_fail_valid=0, internal vec=0, dwell_cnt=0. rst has priority over start.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE/DONE + start=1: at the next edge, latch expected, clear table_out, mismatch_cnt, first_fail and first_fail_valid, and clear done and pass. Set vec=0, dwell_cnt=0 and go to APPLY.
- APPLY: abcd_out=vec. dwell_cnt increments each cycle. When dwell_cnt==DWELL-1, go to SAMPLE and clear dwell_cnt.
- SAMPLE: abcd_out=vec, which is still stable. At the edge:
  - table_out[vec] <= f_in.
  - If f_in != expected_latched[vec]: mismatch_cnt increments.
  - If that is the first mismatch of the sweep: first_fail <= vec and first_fail_valid <= 1.
  - If vec == 2**N_IN-1: go to DONE. Otherwise vec increments and the state goes to APPLY.
- Each vector is stable for DWELL+1 cycles. DONE is entered exactly 16*(DWELL+1) edges after the start-accept edge.
- DONE: done=1. pass = (mismatch_cnt==0), registered on DONE entry. abcd_out=0. Results are held stable.
- Outside APPLY/SAMPLE, abcd_out=0. busy = state is APPLY or SAMPLE.
- start while busy: ignored. The sweep is not restarted and expected is not re-latched.
- start held high continuously: a new sweep begins on every entry into DONE followed by one DONE cycle. Restart happens at the first edge in DONE, so done is high for exactly 1 cycle.
- Changes on expected after start is accepted have no effect until the next accepted start.
- mismatch_cnt saturation is not needed; the width holds 16.
- All outputs are registered except abcd_out and busy, which decode from registered state and vec.

Test Plan:
- Parity DUT model (f = A^B^C^D), expected=16'h6996, DWELL=2, pulse start → done rises 48 edges after the accept edge. table_out=16'h6996, pass=1, mismatch_cnt=0, first_fail_valid=0.
- Same DUT, expected=16'h6997 → pass=0, mismatch_cnt=1, first_fail=0, first_fail_valid=1. Expected=16'h2996 → first_fail=14.
- Same DUT, expected=16'h9669 (all bits wrong) → mismatch_cnt=16, first_fail=0, table_out=16'h6996.
- Monitor abcd_out during a DWELL=2 sweep → sequence 0,1,…,15, each value held exactly 3 cycles. abcd_out=0 in IDLE and DONE. busy high exactly 48 cycles.
- Pulse start again at vec=5, and change expected mid-sweep → no restart. Results match the originally latched expected.
- Assert rst while vec=9 → next cycle state IDLE with all outputs 0. A subsequent start performs a full clean sweep with correct results.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper for an N_IN-input combinational block: applies every input vector
// in ascending order, samples f after a dwell, and compares the measured table to an expected one.
module truth_table_sweeper #(
    parameter int N_IN  = 4,
    parameter int DWELL = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      abcd_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_valid
);

    localparam int W = 2**N_IN;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_APPLY  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]      DW_LAST  = 4'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    logic [1:0]      r_state;
    logic [N_IN-1:0] r_vec;
    logic [3:0]      r_dwell;
    logic [W-1:0]    r_exp;
    logic [W-1:0]    r_table;
    logic [N_IN:0]   r_mcnt;
    logic [N_IN-1:0] r_ff;
    logic            r_ffv;
    logic            r_done;
    logic            r_pass;

    logic            w_busy;
    logic            w_miss;
    logic [N_IN:0]   w_mcnt_next;

    assign w_busy      = (r_state == S_APPLY) || (r_state == S_SAMPLE);
    assign w_miss      = f_in ^ r_exp[r_vec];
    assign w_mcnt_next = r_mcnt + {{N_IN{1'b0}}, w_miss};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_dwell <= '0;
            r_exp   <= '0;
            r_table <= '0;
            r_mcnt  <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_exp   <= expected;
                        r_table <= '0;
                        r_mcnt  <= '0;
                        r_ff    <= '0;
                        r_ffv   <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_vec   <= '0;
                        r_dwell <= '0;
                        r_state <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (r_dwell == DW_LAST) begin
                        r_dwell <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_dwell <= r_dwell + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_table[r_vec] <= f_in;
                    if (w_miss) begin
                        r_mcnt <= w_mcnt_next;
                        if (!r_ffv) begin
                            r_ff  <= r_vec;
                            r_ffv <= 1'b1;
                        end
                    end
                    // pass must reflect this final sample, so use the next count
                    if (r_vec == VEC_LAST) begin
                        r_done  <= 1'b1;
                        r_pass  <= (w_mcnt_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_state <= S_APPLY;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy             = w_busy;
    assign abcd_out         = w_busy ? r_vec : '0;
    assign done             = r_done;
    assign pass             = r_pass;
    assign table_out        = r_table;
    assign mismatch_cnt     = r_mcnt;
    assign first_fail       = r_ff;
    assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: the function block is a lookup table driven by the bench,
// and results are predicted from table arithmetic (xor, popcount, lowest set bit).
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic [3:0]  abcd_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        first_fail_valid;

    logic [15:0] lut;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign f_in = lut[abcd_out];

    truth_table_sweeper #(.N_IN(4), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f_in),
        .abcd_out(abcd_out), .busy(busy), .done(done), .pass(pass),
        .table_out(table_out), .mismatch_cnt(mismatch_cnt),
        .first_fail(first_fail), .first_fail_valid(first_fail_valid)
    );

    function automatic int popcnt16(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int lowest16(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Pulse start with table e; edges = edges from accept to done, -1 on timeout.
    task automatic do_sweep(input logic [15:0] e, output int edges);
        start = 1'b1; expected = e;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!done) edges = -1;
    endtask

    task automatic check_results(input string name, input logic [15:0] e);
        logic [15:0] diff;
        int mc;
        diff = lut ^ e;
        mc = popcnt16(diff);
        checks++;
        if (table_out !== lut) begin
            errors++; $display("FAIL %s table_out got %h want %h", name, table_out, lut);
        end
        checks++;
        if (int'(mismatch_cnt) != mc) begin
            errors++; $display("FAIL %s mismatch_cnt got %0d want %0d", name, mismatch_cnt, mc);
        end
        checks++;
        if (pass !== (mc == 0)) begin
            errors++; $display("FAIL %s pass got %b want %b", name, pass, mc == 0);
        end
        checks++;
        if (first_fail_valid !== (mc != 0)) begin
            errors++; $display("FAIL %s first_fail_valid got %b want %b", name, first_fail_valid, mc != 0);
        end
        if (mc != 0) begin
            checks++;
            if (int'(first_fail) != lowest16(diff)) begin
                errors++; $display("FAIL %s first_fail got %0d want %0d", name, first_fail, lowest16(diff));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; expected = 16'h0; lut = 16'h6996;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks++;
        if ({abcd_out, busy, done, pass, table_out, mismatch_cnt, first_fail, first_fail_valid} !== '0) begin
            errors++;
            $display("FAIL reset outputs got abcd=%h busy=%b done=%b pass=%b tbl=%h mc=%0d ff=%0d ffv=%b want all 0",
                     abcd_out, busy, done, pass, table_out, mismatch_cnt, first_fail, first_fail_valid);
        end
    endtask

    task automatic test_parity();
        int edges;
        lut = 16'h6996;
        do_sweep(16'h6996, edges);
        checks++;
        if (edges != 48) begin errors++; $display("FAIL parity_latency got %0d want 48", edges); end
        check_results("parity_match", 16'h6996);
        do_sweep(16'h6997, edges);
        check_results("parity_bit0", 16'h6997);
        do_sweep(16'h2996, edges);
        check_results("parity_bit14", 16'h2996);
        do_sweep(16'h9669, edges);
        check_results("parity_allwrong", 16'h9669);
    endtask

    task automatic test_sequence();
        int nbusy = 0;
        int bad = 0;
        int doneseen = 0;
        lut = 16'h6996;
        checks++;
        if (abcd_out !== 4'd0) begin errors++; $display("FAIL seq_abcd_done got %0d want 0", abcd_out); end
        start = 1'b1; expected = 16'h6996;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (busy) begin
                if (int'(abcd_out) != nbusy / 3) bad++;
                nbusy++;
            end else if (abcd_out !== 4'd0) begin
                bad++;
            end
            if (done) doneseen++;
            @(posedge clk); #1;
        end
        checks++;
        if (nbusy != 48) begin errors++; $display("FAIL seq_busy_cycles got %0d want 48", nbusy); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL seq_abcd_order got %0d bad cycles want 0", bad); end
        checks++;
        if (doneseen != 12) begin errors++; $display("FAIL seq_done_hold got %0d want 12", doneseen); end
    endtask

    task automatic test_start_while_busy();
        int edges = 0;
        logic [15:0] e0;
        lut = 16'($urandom);
        e0 = lut ^ 16'h0120;
        start = 1'b1; expected = e0;
        @(posedge clk); #1;
        start = 1'b0;
        while (abcd_out != 4'd5 && edges < 100) begin @(posedge clk); #1; edges++; end
        start = 1'b1; expected = ~e0;
        @(posedge clk); #1; edges++;
        start = 1'b0; expected = 16'($urandom);
        while (!done && edges < 200) begin @(posedge clk); #1; edges++; end
        checks++;
        if (edges != 48) begin errors++; $display("FAIL busy_start_latency got %0d want 48", edges); end
        check_results("busy_start", e0);
    endtask

    task automatic test_reset_mid_sweep();
        int edges = 0;
        lut = 16'($urandom);
        start = 1'b1; expected = ~lut;
        @(posedge clk); #1;
        start = 1'b0;
        while (abcd_out != 4'd9 && edges < 100) begin @(posedge clk); #1; edges++; end
        checks++;
        if (abcd_out !== 4'd9) begin errors++; $display("FAIL midrst_reach got %0d want 9", abcd_out); end
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        checks++;
        if ({abcd_out, busy, done, pass, table_out, mismatch_cnt, first_fail, first_fail_valid} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got abcd=%h busy=%b done=%b tbl=%h mc=%0d ffv=%b want all 0",
                     abcd_out, busy, done, table_out, mismatch_cnt, first_fail_valid);
        end
        expected = lut ^ 16'h8001;
        do_sweep(16'h0, edges);
        do_sweep(lut ^ 16'h8001, edges);
        checks++;
        if (edges != 48) begin errors++; $display("FAIL midrst_latency got %0d want 48", edges); end
        check_results("midrst_sweep", lut ^ 16'h8001);
    endtask

    task automatic test_random();
        int edges;
        logic [15:0] e;
        for (int n = 0; n < 6; n++) begin
            lut = 16'($urandom);
            case (n % 3)
                0: e = lut;
                1: e = lut ^ (16'h1 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            do_sweep(e, edges);
            checks++;
            if (edges != 48) begin errors++; $display("FAIL random_latency got %0d want 48", edges); end
            check_results("random", e);
        end
    endtask

    task automatic test_start_held();
        int edges = 0;
        lut = 16'h6996;
        start = 1'b1; expected = 16'h6996;
        @(posedge clk); #1;
        while (!done && edges < 200) begin @(posedge clk); #1; edges++; end
        checks++;
        if (edges != 48) begin errors++; $display("FAIL held_latency got %0d want 48", edges); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL held_restart got done=%b busy=%b want done=0 busy=1", done, busy);
        end
        start = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin @(posedge clk); #1; edges++; end
        checks++;
        if (edges != 48) begin errors++; $display("FAIL held_second_latency got %0d want 48", edges); end
        check_results("held_second", 16'h6996);
    endtask

    initial begin
        test_reset();
        test_parity();
        test_sequence();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_random();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
